multi_debounce: RTL and testbench

//  N-channel button conditioner for Basys-class boards: synchronises raw pushbutton inputs,

---
 rtl/multi_debounce_if.sv | 23 ++
 rtl/multi_debounce.sv | 143 ++++++++++++++
 tb/tb_multi_debounce.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_debounce_if.sv
// Button conditioner bus: raw buttons in, debounced level and strobes out.
// The release and auto-repeat strobes are named release_pulse/repeat_pulse
// because plain "release" and "repeat" are reserved words in SystemVerilog.
interface multi_debounce_if #(
  parameter int N_CH = 5
);
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;
  logic            tick;

  modport master (
    output button,
    input  level, press, release_pulse, repeat_pulse, tick
  );

  modport slave (
    input  button,
    output level, press, release_pulse, repeat_pulse, tick
  );
endinterface

// File: rtl/multi_debounce.sv
// N-channel pushbutton conditioner: 2-flop synchroniser, tick-sampled
// stability counter per channel, registered press/release strobes and an
// optional hold-to-auto-repeat strobe.
module multi_debounce #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SAMPLE_HZ    = 100,
  parameter int N_CH         = 5,
  parameter int STABLE_CNT   = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                clock,
  input  logic                reset,
  multi_debounce_if.slave     bus
);

  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TW       = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // Stability counter only ever holds 0..STABLE_CNT-1.
  localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [N_CH-1:0] sync_a;
  logic [N_CH-1:0] sync_b;
  logic [N_CH-1:0] level_r;
  logic [N_CH-1:0] level_next;
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] press_r;
  logic [N_CH-1:0] release_r;
  logic [N_CH-1:0] repeat_r;
  logic [SW-1:0]   stab [N_CH];

  // Shared sample-rate divider; tick is high for the last count of each period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= bus.button;
      sync_b <= sync_a;
    end
  end

  // A channel flips when the final disagreeing sample of a qualifying run arrives.
  always_comb begin
    toggle = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      toggle[ch] = tick && (sync_b[ch] != level_r[ch]) && (stab[ch] == STAB_LAST);
    end
    level_next = level_r ^ toggle;
  end

  // Level, edge strobes and stability counters; any agreeing sample restarts qualification.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_r   <= '0;
      press_r   <= '0;
      release_r <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        stab[ch] <= '0;
      end
    end else begin
      level_r   <= level_next;
      press_r   <= toggle & level_next;
      release_r <= toggle & ~level_next;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (tick) begin
          if (sync_b[ch] == level_r[ch]) begin
            stab[ch] <= '0;
          end else if (stab[ch] == STAB_LAST) begin
            stab[ch] <= '0;
          end else begin
            stab[ch] <= stab[ch] + 1'b1;
          end
        end
      end
    end
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      // hold_cnt runs 0..DELAY+RATE-1 and reloads to DELAY, so it never wraps.
      localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE);
      localparam logic [HW-1:0] HOLD_FIRST  = HW'(REPEAT_DELAY);
      localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY + REPEAT_RATE - 1);

      logic [HW-1:0] hold_cnt [N_CH];

      // Count held ticks (not the press tick itself) and strobe at DELAY, then every RATE.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          repeat_r <= '0;
          for (int ch = 0; ch < N_CH; ch++) begin
            hold_cnt[ch] <= '0;
          end
        end else begin
          for (int ch = 0; ch < N_CH; ch++) begin
            if (!level_next[ch]) begin
              hold_cnt[ch] <= '0;
              repeat_r[ch] <= 1'b0;
            end else if (tick && level_r[ch]) begin
              if (hold_cnt[ch] == HOLD_RELOAD) begin
                hold_cnt[ch] <= HOLD_FIRST;
                repeat_r[ch] <= 1'b1;
              end else begin
                hold_cnt[ch] <= hold_cnt[ch] + 1'b1;
                repeat_r[ch] <= ((hold_cnt[ch] + 1'b1) == HOLD_FIRST);
              end
            end else begin
              repeat_r[ch] <= 1'b0;
            end
          end
        end
      end
    end else begin : g_no_repeat
      assign repeat_r = '0;
    end
  endgenerate

  assign bus.level         = level_r;
  assign bus.press         = press_r;
  assign bus.release_pulse = release_r;
  assign bus.repeat_pulse  = repeat_r;
  assign bus.tick          = tick;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce with TICK_DIV=10, STABLE_CNT=3,
// REPEAT_DELAY=4, REPEAT_RATE=2 on two channels.
module tb_multi_debounce;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;
  logic [1:0] lv;
  logic [1:0] pr;
  logic [1:0] rl;
  logic [1:0] rp;

  multi_debounce_if #(.N_CH(2)) bus ();

  multi_debounce #(
    .CLK_HZ(100), .SAMPLE_HZ(10), .N_CH(2), .STABLE_CNT(3),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // 10-unit clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Step negedges until tick is seen; a missing tick counts as a failure.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      @(negedge clock);
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL tick_timeout: actual no tick in 25 cycles, required a tick");
    end
  endtask

  // Drive the buttons, let one tick sample them, read outputs in the cycle after the tick.
  task automatic tick_sample(input logic [1:0] b);
    bus.button = b;
    wait_tick();
    @(negedge clock);
    lv = bus.level;
    pr = bus.press;
    rl = bus.release_pulse;
    rp = bus.repeat_pulse;
  endtask

  task automatic test_reset();
    int first_tick;
    int press_cycle;
    logic [1:0] press_val;
    logic [1:0] level_29;
    logic [1:0] level_30;
    bit rel_seen;
    reset = 1'b1;
    bus.button = 2'b11;
    repeat (3) @(negedge clock);
    n_cmp++; if (bus.level !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_level: actual %b required 00", bus.level); end
    n_cmp++; if (bus.press !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_press: actual %b required 00", bus.press); end
    n_cmp++; if (bus.release_pulse !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_release: actual %b required 00", bus.release_pulse); end
    n_cmp++; if (bus.repeat_pulse !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_repeat: actual %b required 00", bus.repeat_pulse); end
    n_cmp++; if (bus.tick !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tick: actual %b required 0", bus.tick); end
    reset = 1'b0;
    first_tick = -1;
    press_cycle = -1;
    press_val = 2'b00;
    level_29 = 2'bxx;
    level_30 = 2'bxx;
    rel_seen = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (bus.tick === 1'b1 && first_tick < 0) first_tick = c;
      if (bus.press !== 2'b00 && press_cycle < 0) begin
        press_cycle = c;
        press_val = bus.press;
      end
      if (bus.release_pulse !== 2'b00) rel_seen = 1'b1;
      if (c == 29) level_29 = bus.level;
      if (c == 30) level_30 = bus.level;
    end
    n_cmp++; if (first_tick != 9) begin n_fail++; $display("[TB] FAIL first_tick: actual cycle %0d required 9", first_tick); end
    n_cmp++; if (press_cycle != 30) begin n_fail++; $display("[TB] FAIL press_cycle: actual %0d required 30", press_cycle); end
    n_cmp++; if (press_val !== 2'b11) begin n_fail++; $display("[TB] FAIL press_value: actual %b required 11", press_val); end
    n_cmp++; if (level_29 !== 2'b00) begin n_fail++; $display("[TB] FAIL level_before: actual %b required 00", level_29); end
    n_cmp++; if (level_30 !== 2'b11) begin n_fail++; $display("[TB] FAIL level_after: actual %b required 11", level_30); end
    n_cmp++; if (rel_seen) begin n_fail++; $display("[TB] FAIL no_release: actual release seen required none"); end
    @(negedge clock);
    n_cmp++; if (bus.press !== 2'b00) begin n_fail++; $display("[TB] FAIL press_width: actual %b required 00", bus.press); end
  endtask

  task automatic test_release_both();
    for (int k = 1; k <= 3; k++) begin
      tick_sample(2'b00);
      n_cmp++; if (lv !== ((k == 3) ? 2'b00 : 2'b11)) begin n_fail++; $display("[TB] FAIL relboth_level k=%0d: actual %b", k, lv); end
      n_cmp++; if (rl !== ((k == 3) ? 2'b11 : 2'b00)) begin n_fail++; $display("[TB] FAIL relboth_release k=%0d: actual %b", k, rl); end
      n_cmp++; if (rp !== 2'b00) begin n_fail++; $display("[TB] FAIL relboth_repeat k=%0d: actual %b required 00", k, rp); end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] pattern [7] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int k = 0; k < 7; k++) begin
      tick_sample(pattern[k]);
      n_cmp++; if (pr !== ((k == 6) ? 2'b01 : 2'b00)) begin n_fail++; $display("[TB] FAIL bounce_press k=%0d: actual %b", k, pr); end
      n_cmp++; if (lv !== ((k == 6) ? 2'b01 : 2'b00)) begin n_fail++; $display("[TB] FAIL bounce_level k=%0d: actual %b", k, lv); end
    end
  endtask

  task automatic test_repeat();
    logic [1:0] exp_rp;
    for (int k = 1; k <= 10; k++) begin
      tick_sample(2'b01);
      exp_rp = (k == 4 || k == 6 || k == 8 || k == 10) ? 2'b01 : 2'b00;
      n_cmp++; if (rp !== exp_rp) begin n_fail++; $display("[TB] FAIL repeat hold=%0d: actual %b required %b", k, rp, exp_rp); end
      n_cmp++; if (lv !== 2'b01) begin n_fail++; $display("[TB] FAIL repeat_level hold=%0d: actual %b required 01", k, lv); end
      if (k == 4) begin
        @(negedge clock);
        n_cmp++; if (bus.repeat_pulse !== 2'b00) begin n_fail++; $display("[TB] FAIL repeat_width: actual %b required 00", bus.repeat_pulse); end
      end
    end
  endtask

  task automatic test_release_ch0();
    logic [1:0] exp_lv [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
    logic [1:0] exp_rl [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    logic [1:0] exp_rp [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
    for (int k = 0; k < 4; k++) begin
      tick_sample(2'b00);
      n_cmp++; if (lv !== exp_lv[k]) begin n_fail++; $display("[TB] FAIL rel0_level k=%0d: actual %b required %b", k, lv, exp_lv[k]); end
      n_cmp++; if (rl !== exp_rl[k]) begin n_fail++; $display("[TB] FAIL rel0_release k=%0d: actual %b required %b", k, rl, exp_rl[k]); end
      n_cmp++; if (rp !== exp_rp[k]) begin n_fail++; $display("[TB] FAIL rel0_repeat k=%0d: actual %b required %b", k, rp, exp_rp[k]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 3; k++) begin
      tick_sample(2'b10);
      n_cmp++; if (pr !== ((k == 3) ? 2'b10 : 2'b00)) begin n_fail++; $display("[TB] FAIL b2b_press1 k=%0d: actual %b", k, pr); end
    end
    for (int k = 1; k <= 3; k++) begin
      tick_sample(2'b01);
      n_cmp++; if (pr !== ((k == 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("[TB] FAIL b2b_press k=%0d: actual %b", k, pr); end
      n_cmp++; if (rl !== ((k == 3) ? 2'b10 : 2'b00)) begin n_fail++; $display("[TB] FAIL b2b_release k=%0d: actual %b", k, rl); end
      n_cmp++; if (lv !== ((k == 3) ? 2'b01 : 2'b10)) begin n_fail++; $display("[TB] FAIL b2b_level k=%0d: actual %b", k, lv); end
      n_cmp++; if (rp !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_repeat k=%0d: actual %b required 00", k, rp); end
    end
  endtask

  task automatic test_reset_mid_repeat();
    bit strobe_seen;
    bit level_seen;
    for (int k = 1; k <= 4; k++) begin
      tick_sample(2'b01);
      n_cmp++; if (rp !== ((k == 4) ? 2'b01 : 2'b00)) begin n_fail++; $display("[TB] FAIL midrep_repeat hold=%0d: actual %b", k, rp); end
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.level !== 2'b00) begin n_fail++; $display("[TB] FAIL async_level: actual %b required 00", bus.level); end
    n_cmp++; if (bus.repeat_pulse !== 2'b00) begin n_fail++; $display("[TB] FAIL async_repeat: actual %b required 00", bus.repeat_pulse); end
    n_cmp++; if (bus.release_pulse !== 2'b00) begin n_fail++; $display("[TB] FAIL async_release: actual %b required 00", bus.release_pulse); end
    @(negedge clock);
    bus.button = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    strobe_seen = 1'b0;
    level_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if ((bus.release_pulse | bus.press | bus.repeat_pulse) !== 2'b00) strobe_seen = 1'b1;
      if (bus.level !== 2'b00) level_seen = 1'b1;
    end
    n_cmp++; if (strobe_seen) begin n_fail++; $display("[TB] FAIL post_reset_strobe: actual strobe seen required none"); end
    n_cmp++; if (level_seen) begin n_fail++; $display("[TB] FAIL post_reset_level: actual level rose required 00"); end
  endtask

  // Scenario sequence; each task leaves the DUT in the state the next one expects.
  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.button = 2'b00;
    test_reset();
    test_release_both();
    test_bounce();
    test_repeat();
    test_release_ch0();
    test_back_to_back();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
